sram_mem_controller: RTL
========================

// Module: sram_mem_controller
// PURPOSE
//  Memory-stage controller between the EXEC stage register and the MEM stage register.
//  Serves 32-bit word loads and stores from the 32-bit core by driving an external 16-bit async SRAM.
//  Each word takes two half-word accesses with programmable wait states.
//  While an access is in progress, ready is low and the pipeline freezes.
// PARAMETERS
//  WAIT_CYCLES  3     clock cycles per SRAM half-word access (>=1)
//  BASE_ADDR    1024  byte address that maps to SRAM word 0
// PORTS
//  clk         in     1   clock; all state updates on the rising edge
//  rst         in     1   reset, asynchronous, active-low
//  wr_en       in     1   store request from the EXEC stage register
//  rd_en       in     1   load request from the EXEC stage register
//  address     in     32  byte address (ALU result)
//  write_data  in     32  store value (Rm)
//  read_data   out    32  load result; valid while ready=1 in DONE
//  ready       out    1   0 = freeze the pipeline
//  SRAM_DQ     inout  16  SRAM data bus
//  SRAM_ADDR   out    18  SRAM half-word address
//  SRAM_WE_N   out    1   SRAM write enable, active-low
//  SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1  tied 0
// BEHAVIOUR
//  Reset values (async, rst=0):
//   - state=IDLE, wait counter=0, read_data=0, SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0
//   - ready=1 (no request pending)
//   - reset mid-access abandons it; a half-written SRAM word is left as-is
//  Address mapping:
//   - word = (address - BASE_ADDR) >> 2, mod 2^17
//   - low half at SRAM_ADDR={word[16:0],1'b0}, bits[15:0]; high half at {word[16:0],1'b1}, bits[31:16]
//   - no range check; address[1:0] ignored
//  FSM: IDLE -> {RD_LO->RD_HI | WR_LO->WR_HI} -> DONE -> IDLE
//   - IDLE: on wr_en, go to WR_LO; else on rd_en, go to RD_LO. wr_en&rd_en both high: write wins, no read.
//   - Each LO/HI state lasts exactly WAIT_CYCLES cycles; the counter clears on every state change.
//   - WR_*: SRAM_WE_N=0, DQ driven with the selected half of the latched write data.
//   - RD_*: WE_N=1, DQ=Z; DQ is sampled on the last cycle of the state into the matching half of read_data.
//   - DONE: one cycle, ready=1, read_data holds the full word; next state IDLE.
//   - address and write_data are latched on IDLE exit; input changes mid-access are ignored.
//  ready (combinational) = (state==IDLE & !rd_en & !wr_en) | state==DONE
//   - It drops in the same cycle a request appears.
//   - Freeze length = 2*WAIT_CYCLES+1 cycles from request to the first ready=1 cycle (IDLE + 2*W).
//   - The pipeline advances on the DONE edge. The next request is seen in IDLE on the following cycle (no back-to-back merge).
//  read_data keeps its last value outside DONE and after writes.
// CONFIGURATION
//  SRAM_CTRL_READ_BUF_EN defined: one-entry read buffer (tag = word index, data, valid; valid=0 on reset).
//   - Read hit in IDLE: go straight to DONE with buffered data; freeze = 1 cycle.
//   - Any SRAM read fills the buffer.
//   - A write to the buffered word updates the buffer data (write-through); a write elsewhere leaves it unchanged.
//  Undefined: every read goes to SRAM; no buffer storage is instantiated.
// STRUCTURE
//  Package sram_mem_pkg holds:
//   - state encoding localparams (IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE)
//   - SRAM_DW=16, SRAM_AW=18, default BASE_ADDR
//  Sub-module sram_read_buffer (tag/valid/data, hit compare), instantiated only under SRAM_CTRL_READ_BUF_EN.
//  Wait counter and FSM stay in this module.
// TESTING (WAIT_CYCLES=3, BASE_ADDR=1024)
//  1. Write 0xDEADBEEF @1024 -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; WE_N low 6 cycles; ready 0 for 7 cycles, then 1.
//  2. Read @1024 after test 1 -> read_data=0xDEADBEEF in the DONE cycle; DQ=Z throughout.
//  3. Write 0x12345678 @1028 -> SRAM_ADDR 2 gets 0x5678, SRAM_ADDR 3 gets 0x1234; SRAM[0..1] unchanged.
//  4. rd_en=wr_en=1, addr 1032, data 0xA5A5 -> write performed, read_data keeps its old value.
//  5. rst=0 during WR_HI -> immediately WE_N=1, DQ=Z, ready=1, read_data=0; next request starts cleanly.
//  6. With SRAM_CTRL_READ_BUF_EN: read 1024 twice -> 2nd freeze = 1 cycle;
//     then write 0xCAFEF00D @1024 and read -> 0xCAFEF00D with a 1-cycle freeze.

Source files
------------

// File: rtl/sram_mem_pkg.sv
// ============================================================================
// Module : sram_mem_pkg
// Brief  : Shared constants, state encoding and address mapping for the SRAM
//          memory-stage controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sram_mem_pkg;

    localparam int SRAM_DW = 16;
    localparam int SRAM_AW = 18;
    localparam int WORD_AW = SRAM_AW - 1;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_LO = 3'd1;
    localparam logic [2:0] ST_RD_HI = 3'd2;
    localparam logic [2:0] ST_WR_LO = 3'd3;
    localparam logic [2:0] ST_WR_HI = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        RD_LO = ST_RD_LO,
        RD_HI = ST_RD_HI,
        WR_LO = ST_WR_LO,
        WR_HI = ST_WR_HI,
        DONE  = ST_DONE
    } state_t;

    // Byte address to SRAM word index; wraps modulo the SRAM word count.
    function automatic logic [WORD_AW-1:0] word_index(input logic [31:0] addr,
                                                      input logic [31:0] base);
        logic [31:0] offset;
        offset = addr - base;
        return offset[WORD_AW+1:2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_mem_if.sv
// ============================================================================
// Module : sram_mem_if
// Brief  : Core-side request/response bundle between the pipeline and the
//          SRAM memory-stage controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sram_mem_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

`default_nettype wire

// File: rtl/sram_read_buffer.sv
// ============================================================================
// Module : sram_read_buffer
// Brief  : One-entry read buffer (tag, data, valid) with hit compare; exists
//          only when SRAM_CTRL_READ_BUF_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifdef SRAM_CTRL_READ_BUF_EN
module sram_read_buffer
    import sram_mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_AW-1:0] lookup_tag,
    output logic               hit,
    output logic [31:0]        hit_data,
    input  logic               fill_en,
    input  logic [WORD_AW-1:0] fill_tag,
    input  logic [31:0]        fill_data,
    input  logic               upd_en,
    input  logic [WORD_AW-1:0] upd_tag,
    input  logic [31:0]        upd_data
);
    logic               valid;
    logic [WORD_AW-1:0] tag;
    logic [31:0]        data;

    assign hit      = valid && (tag == lookup_tag);
    assign hit_data = data;

    // Writes to the buffered word keep the entry coherent with the SRAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
        end else if (upd_en && valid && (tag == upd_tag)) begin
            data  <= upd_data;
        end
    end
endmodule
`endif

`default_nettype wire

// File: rtl/sram_mem_controller.sv
// ============================================================================
// Module : sram_mem_controller
// Brief  : Memory-stage controller serving 32-bit loads/stores through a
//          16-bit async SRAM; optional read buffer via SRAM_CTRL_READ_BUF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_mem_controller
    import sram_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    sram_mem_if.slave          bus,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);
    localparam int                CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WAIT_CYCLES - 1);

    state_t               state;
    logic [CNT_W-1:0]     wait_cnt;
    logic [WORD_AW-1:0]   word_q;
    logic [15:0]          wdata_hi_q;
    logic [15:0]          rdata_lo_q;
    logic [31:0]          read_data_q;
    logic [SRAM_AW-1:0]   sram_addr_q;
    logic                 we_n_q;
    logic                 dq_oe_q;
    logic [SRAM_DW-1:0]   dq_out_q;

    logic [WORD_AW-1:0]   word_in;
    logic                 last;
    logic                 buf_hit;
    logic [31:0]          buf_data;

    assign word_in = word_index(bus.address, BASE_ADDR);
    assign last    = (wait_cnt == LAST);

`ifdef SRAM_CTRL_READ_BUF_EN
    sram_read_buffer u_read_buffer (
        .clk        (clk),
        .rst        (rst),
        .lookup_tag (word_in),
        .hit        (buf_hit),
        .hit_data   (buf_data),
        .fill_en    ((state == RD_HI) && last),
        .fill_tag   (word_q),
        .fill_data  ({SRAM_DQ, rdata_lo_q}),
        .upd_en     ((state == IDLE) && bus.wr_en),
        .upd_tag    (word_in),
        .upd_data   (bus.write_data)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    // read_data only changes on DONE entry so it holds its value mid-access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            word_q      <= '0;
            wdata_hi_q  <= '0;
            rdata_lo_q  <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (bus.wr_en) begin
                        state       <= WR_LO;
                        word_q      <= word_in;
                        wdata_hi_q  <= bus.write_data[31:16];
                        sram_addr_q <= {word_in, 1'b0};
                        we_n_q      <= 1'b0;
                        dq_oe_q     <= 1'b1;
                        dq_out_q    <= bus.write_data[15:0];
                    end else if (bus.rd_en) begin
                        word_q <= word_in;
                        if (buf_hit) begin
                            state       <= DONE;
                            read_data_q <= buf_data;
                        end else begin
                            state       <= RD_LO;
                            sram_addr_q <= {word_in, 1'b0};
                        end
                    end
                end
                WR_LO: begin
                    if (last) begin
                        state       <= WR_HI;
                        wait_cnt    <= '0;
                        sram_addr_q <= {word_q, 1'b1};
                        dq_out_q    <= wdata_hi_q;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WR_HI: begin
                    if (last) begin
                        state    <= DONE;
                        wait_cnt <= '0;
                        we_n_q   <= 1'b1;
                        dq_oe_q  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RD_LO: begin
                    if (last) begin
                        state       <= RD_HI;
                        wait_cnt    <= '0;
                        rdata_lo_q  <= SRAM_DQ;
                        sram_addr_q <= {word_q, 1'b1};
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RD_HI: begin
                    if (last) begin
                        state       <= DONE;
                        wait_cnt    <= '0;
                        read_data_q <= {SRAM_DQ, rdata_lo_q};
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.ready     = ((state == IDLE) && !bus.rd_en && !bus.wr_en) || (state == DONE);
    assign bus.read_data = read_data_q;

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

`default_nettype wire
